// File: rtl/packing_line_ctrl_if.sv
// Packing line control/status bundle between the sequencing controller and the line.
// master = controller side, slave = line/sensor side.
interface packing_line_ctrl_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             start;
  logic             item_sense;
  logic             seal_ack;
  logic             conveyor_en;
  logic             seal_req;
  logic [CNT_W-1:0] item_cnt;
  logic [CNT_W-1:0] box_cnt;
  logic             batch_done;
  logic             fault;

  modport master (
    input  start, item_sense, seal_ack,
    output conveyor_en, seal_req, item_cnt, box_cnt, batch_done, fault
  );

  modport slave (
    output start, item_sense, seal_ack,
    input  conveyor_en, seal_req, item_cnt, box_cnt, batch_done, fault
  );
endinterface

// File: rtl/packing_line_ctrl.sv
// Packing line sequencer: counts items, runs the four-phase seal handshake, counts boxes.
// Optional seal watchdog enabled by defining SEAL_TIMEOUT_EN.
module packing_line_ctrl #(
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned ITEMS_PER_BOX   = 10,
  parameter int unsigned BOXES_PER_BATCH = 10,
  parameter int unsigned SEAL_TIMEOUT    = 255,
  parameter int unsigned TO_W            = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  packing_line_ctrl_if.master line
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SEAL,
    S_SEAL_REL,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] ITEM_LAST = CNT_W'(ITEMS_PER_BOX);
  localparam logic [CNT_W-1:0] BOX_LAST  = CNT_W'(BOXES_PER_BATCH);

  // Elaboration-time parameter sanity checks
  if (ITEMS_PER_BOX < 1 || ITEMS_PER_BOX > (2**CNT_W - 1)) begin : g_bad_items
    $error("ITEMS_PER_BOX out of range for CNT_W");
  end
  if (BOXES_PER_BATCH < 1 || BOXES_PER_BATCH > (2**CNT_W - 1)) begin : g_bad_boxes
    $error("BOXES_PER_BATCH out of range for CNT_W");
  end
  if (SEAL_TIMEOUT < 1 || SEAL_TIMEOUT > (2**TO_W - 1)) begin : g_bad_timeout
    $error("SEAL_TIMEOUT out of range for TO_W");
  end

  logic sync1_q, sync2_q, dly_q;
  logic item_edge;

  state_t           state_q, state_d;
  logic             conv_q, conv_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] item_q, item_d;
  logic [CNT_W-1:0] box_q, box_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] item_inc, box_inc;

`ifdef SEAL_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(SEAL_TIMEOUT);
  logic             fault_q, fault_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic [TO_W-1:0]  wd_inc;
  assign wd_inc = wd_q + TO_W'(1);
`endif

  // Metastability synchroniser plus delay stage for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= line.item_sense;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign item_edge = sync2_q & ~dly_q;
  assign item_inc  = item_q + CNT_W'(1);
  assign box_inc   = box_q + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    conv_d  = conv_q;
    req_d   = req_q;
    item_d  = item_q;
    box_d   = box_q;
    done_d  = done_q;
`ifdef SEAL_TIMEOUT_EN
    fault_d = fault_q;
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        conv_d = 1'b0;
        req_d  = 1'b0;
        if (line.start) begin
          state_d = S_FILL;
          item_d  = '0;
          box_d   = '0;
          done_d  = 1'b0;
          conv_d  = 1'b1;
        end
      end

      S_FILL: begin
        conv_d = 1'b1;
        req_d  = 1'b0;
        if (item_edge) begin
          item_d = item_inc;
          if (item_inc == ITEM_LAST) begin
            state_d = S_SEAL;
            conv_d  = 1'b0;
            req_d   = 1'b1;
`ifdef SEAL_TIMEOUT_EN
            wd_d    = '0;
`endif
          end
        end
      end

      S_SEAL: begin
        conv_d = 1'b0;
        req_d  = 1'b1;
        if (line.seal_ack) begin
          state_d = S_SEAL_REL;
          req_d   = 1'b0;
        end
`ifdef SEAL_TIMEOUT_EN
        else begin
          wd_d = wd_inc;
          if (wd_inc == TO_LIMIT) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            req_d   = 1'b0;
          end
        end
`endif
      end

      S_SEAL_REL: begin
        conv_d = 1'b0;
        req_d  = 1'b0;
        if (!line.seal_ack) begin
          item_d = '0;
          box_d  = box_inc;
          if (box_inc == BOX_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FILL;
            conv_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        conv_d = 1'b0;
        req_d  = 1'b0;
        done_d = 1'b1;
        if (line.start) begin
          state_d = S_FILL;
          item_d  = '0;
          box_d   = '0;
          done_d  = 1'b0;
          conv_d  = 1'b1;
        end
      end

`ifdef SEAL_TIMEOUT_EN
      // Counts stay frozen for inspection; the following IDLE start clears them
      S_FAULT: begin
        conv_d  = 1'b0;
        req_d   = 1'b0;
        fault_d = 1'b1;
        if (line.start) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        conv_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      conv_q  <= 1'b0;
      req_q   <= 1'b0;
      item_q  <= '0;
      box_q   <= '0;
      done_q  <= 1'b0;
`ifdef SEAL_TIMEOUT_EN
      fault_q <= 1'b0;
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      conv_q  <= conv_d;
      req_q   <= req_d;
      item_q  <= item_d;
      box_q   <= box_d;
      done_q  <= done_d;
`ifdef SEAL_TIMEOUT_EN
      fault_q <= fault_d;
      wd_q    <= wd_d;
`endif
    end
  end

  assign line.conveyor_en = conv_q;
  assign line.seal_req    = req_q;
  assign line.item_cnt    = item_q;
  assign line.box_cnt     = box_q;
  assign line.batch_done  = done_q;
`ifdef SEAL_TIMEOUT_EN
  assign line.fault       = fault_q;
`else
  assign line.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_packing_line_ctrl.sv
// Scoreboard bench for packing_line_ctrl: stimulus pushes expected output tuples,
// a monitor pops one whenever the DUT's observable outputs change.
module tb_packing_line_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IPB   = 10;
  localparam int unsigned BPB   = 10;
`ifdef SEAL_TIMEOUT_EN
  localparam int unsigned TO    = 16;
`else
  localparam int unsigned TO    = 255;
`endif
  localparam int unsigned TW    = 2*CNT_W + 4;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_SEAL  = 2;
  localparam int P_REL   = 3;
  localparam int P_DONE  = 4;
  localparam int P_FAULT = 5;

  logic clk;
  logic rst_n;

  packing_line_ctrl_if #(.CNT_W(CNT_W)) line ();

  packing_line_ctrl #(
    .CNT_W(CNT_W), .ITEMS_PER_BOX(IPB), .BOXES_PER_BATCH(BPB),
    .SEAL_TIMEOUT(TO), .TO_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .line (line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [TW-1:0] exp_q[$];

  // Behavioural model of the line as seen on the outputs
  int   m_phase = P_IDLE;
  int   m_items = 0;
  int   m_boxes = 0;
  logic m_conv = 1'b0, m_req = 1'b0, m_done = 1'b0, m_fault = 1'b0;
  logic [TW-1:0] m_last = '0;

  function automatic logic [TW-1:0] obs_tuple();
    return {line.conveyor_en, line.seal_req, line.item_cnt, line.box_cnt,
            line.batch_done, line.fault};
  endfunction

  task automatic push_model();
    logic [TW-1:0] t;
    t = {m_conv, m_req, CNT_W'(m_items), CNT_W'(m_boxes), m_done, m_fault};
    if (t != m_last) begin
      exp_q.push_back(t);
      m_last = t;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output change must match the next expected tuple
  initial begin
    logic [TW-1:0] prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = obs_tuple();
      if (cur !== prev) begin
        prev = cur;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h expected no change at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL sb_tuple: got %h expected %h at %0t", cur, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic do_start();
    @(posedge clk); #1 line.start = 1'b1;
    case (m_phase)
      P_IDLE, P_DONE: begin
        m_items = 0; m_boxes = 0; m_done = 1'b0; m_conv = 1'b1; m_phase = P_FILL;
      end
      P_FAULT: begin
        m_fault = 1'b0; m_phase = P_IDLE;
      end
      default: ;
    endcase
    push_model();
    @(posedge clk); #1 line.start = 1'b0;
  endtask

  task automatic item_pulse(input int h, input int l);
    @(posedge clk); #1 line.item_sense = 1'b1;
    if (m_phase == P_FILL) begin
      m_items++;
      if (m_items == IPB) begin
        m_phase = P_SEAL; m_conv = 1'b0; m_req = 1'b1;
      end
    end
    push_model();
    repeat (h) @(posedge clk);
    #1 line.item_sense = 1'b0;
    repeat (l) @(posedge clk);
  endtask

  task automatic seal_hs(input int hold);
    @(posedge clk); #1 line.seal_ack = 1'b1;
    if (m_phase == P_SEAL) begin
      m_req = 1'b0; m_phase = P_REL;
    end
    push_model();
    repeat (hold) @(posedge clk);
    #1 line.seal_ack = 1'b0;
    if (m_phase == P_REL) begin
      m_items = 0; m_boxes++;
      if (m_boxes == BPB) begin
        m_done = 1'b1; m_phase = P_DONE;
      end else begin
        m_conv = 1'b1; m_phase = P_FILL;
      end
    end
    push_model();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bit t6_done;
    t6_done = 1'b0;
    rst_n = 1'b0;
    line.start = 1'b0; line.item_sense = 1'b0; line.seal_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_conveyor", int'(line.conveyor_en), 0);
    chk("reset_item_cnt", int'(line.item_cnt), 0);
    chk("reset_fault", int'(line.fault), 0);

    // Reset asserted mid-FILL clears outputs in the same cycle
    do_start();
    for (int i = 0; i < 5; i++) item_pulse(4, 4);
    @(negedge clk);
    chk("fill_item5", int'(line.item_cnt), 5);
    m_phase = P_IDLE; m_items = 0; m_boxes = 0;
    m_conv = 1'b0; m_req = 1'b0; m_done = 1'b0; m_fault = 1'b0;
    push_model();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_conv", int'(line.conveyor_en), 0);
    chk("async_rst_items", int'(line.item_cnt), 0);
    chk("async_rst_req", int'(line.seal_req), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    item_pulse(3, 3);
    @(negedge clk);
    chk("idle_no_start_conv", int'(line.conveyor_en), 0);
    chk("idle_item_ignored", int'(line.item_cnt), 0);

    // Full first box with 4/4 pulses
    do_start();
    @(negedge clk);
    chk("start_conv", int'(line.conveyor_en), 1);
    for (int i = 1; i <= 10; i++) begin
      item_pulse(4, 4);
      @(negedge clk);
      chk("item_step", int'(line.item_cnt), i);
    end
    chk("seal_req_up", int'(line.seal_req), 1);
    chk("seal_conv_off", int'(line.conveyor_en), 0);
    seal_hs(3);
    @(negedge clk);
    chk("box1_cnt", int'(line.box_cnt), 1);
    chk("box1_items", int'(line.item_cnt), 0);
    chk("box1_conv", int'(line.conveyor_en), 1);

    // Held level counts once; pulses during SEAL ignored
    item_pulse(20, 4);
    @(negedge clk);
    chk("held_once", int'(line.item_cnt), 1);
    while (m_phase == P_FILL) item_pulse(3, 3);
    item_pulse(2, 2);
    @(negedge clk);
    chk("seal_items_frozen", int'(line.item_cnt), 10);
    seal_hs(2);

    // start in FILL ignored
    for (int i = 0; i < 3; i++) item_pulse(2, 3);
    do_start();
    @(negedge clk);
    chk("start_in_fill_items", int'(line.item_cnt), 3);
    chk("start_in_fill_conv", int'(line.conveyor_en), 1);

    // Randomised remainder of the batch
    while (m_phase != P_DONE) begin
      if (m_phase == P_FILL) begin
        if ($urandom_range(7) == 0) begin
          do_start();
          @(negedge clk);
          chk("rand_start_ignored", int'(line.item_cnt), m_items);
        end
        item_pulse(int'($urandom_range(6, 2)), int'($urandom_range(6, 2)));
      end else if (m_phase == P_SEAL && m_boxes == 3 && !t6_done) begin
        t6_done = 1'b1;
`ifdef SEAL_TIMEOUT_EN
        m_fault = 1'b1; m_req = 1'b0; m_phase = P_FAULT;
        push_model();
        repeat (TO + 4) @(posedge clk);
        @(negedge clk);
        chk("wd_fault", int'(line.fault), 1);
        chk("wd_req_drop", int'(line.seal_req), 0);
        chk("wd_items_held", int'(line.item_cnt), IPB);
        do_start();
        @(negedge clk);
        chk("fault_clear", int'(line.fault), 0);
        chk("fault_counts_held", int'(line.box_cnt), 3);
        do_start();
`else
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("no_wd_req_held", int'(line.seal_req), 1);
        chk("no_wd_fault", int'(line.fault), 0);
        seal_hs(int'($urandom_range(4, 1)));
`endif
      end else begin
        seal_hs(int'($urandom_range(4, 1)));
      end
    end

    @(negedge clk);
    chk("done_boxes", int'(line.box_cnt), BPB);
    chk("done_led", int'(line.batch_done), 1);
    chk("done_conv", int'(line.conveyor_en), 0);
    for (int i = 0; i < 3; i++) item_pulse(3, 3);
    @(negedge clk);
    chk("done_items_ignored", int'(line.item_cnt), 0);
    do_start();
    @(negedge clk);
    chk("restart_boxes", int'(line.box_cnt), 0);
    chk("restart_led", int'(line.batch_done), 0);
    chk("restart_conv", int'(line.conveyor_en), 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
